systolic_array_nxn: RTL and testbench
=====================================

# systolic_array_nxn

Parametrised output-stationary N×N systolic matrix-multiply engine, the generalised successor to the fixed 2×2 array. It computes C = A·B for an N×K by K×N product with run-time K. Operand skewing is done internally, and signed or unsigned arithmetic is selectable per job. Results are committed into a double-buffered output bank, so a finished result stays readable while the next job computes. It sits between the LSTM operand fetch logic and the activation/accumulate stage.

## Interface
- `N`, 4: array dimension (rows of A = columns of B = N), ≥2
- `DATA_W`, 8: operand width
- `MAX_K`, 16: maximum inner dimension per job
- `KW`, $clog2(MAX_K+1): width of `k_len`
- `ACC_W`, 2*DATA_W+$clog2(MAX_K): accumulator/result width

Ports:
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: job request, sampled only in IDLE
- `k_len` in KW: inner dimension for the job, sampled with `start`
- `signed_mode` in 1: 1 = two's-complement operands, sampled with `start`
- `in_valid` in 1: operand beat valid
- `in_ready` out 1: block accepts beats (high only in FEED)
- `a_col` in N*DATA_W: A[i][k] at `[i*DATA_W +: DATA_W]`
- `b_row` in N*DATA_W: B[k][j] at `[j*DATA_W +: DATA_W]`
- `c_out` out N*N*ACC_W: C[i][j] at `[(i*N+j)*ACC_W +: ACC_W]`, taken from the read bank
- `active_buffer` out 1: index of the bank currently driven on `c_out`
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse after commit

## Operation
- FSM states: IDLE → FEED → DRAIN → COMMIT → IDLE.
- **IDLE**
  - On `start`, the block latches `k_len` (values > MAX_K clamp to MAX_K) and `signed_mode`.
  - It clears all PE accumulators and skew registers.
  - It goes to FEED, or to DRAIN directly if `k_len`=0.
- **FEED**
  - `in_ready`=1.
  - Each cycle with `in_valid` high is one accepted beat k (k counts from 0).
  - After `k_len` beats the block goes to DRAIN.
- **Skew**
  - Row i of A passes through i delay registers.
  - Column j of B passes through j delay registers.
  - Every cycle a non-accepted beat (`in_valid`=0 in FEED, or any cycle outside FEED) injects zeros. Bubbles therefore never corrupt sums.
- **PE(i,j)**
  - The PE registers its A operand to the right and its B operand downward.
  - It accumulates `acc += a*b`, with operands sign-extended when `signed_mode`=1 and zero-extended otherwise.
  - Accumulators wrap modulo 2^ACC_W; no saturation.
- **DRAIN**
  - Fixed 2N−1 cycles, counted by an internal counter, then the FSM goes to COMMIT.
- **COMMIT** (1 cycle)
  - All N² accumulators are copied into bank `~active_buffer`.
  - `active_buffer` toggles on the same edge.
  - `done` rises for one cycle.
- `c_out` changes only at a commit edge and is otherwise stable, including throughout the next job.
- `start` while `busy` is ignored (not queued).
- `in_valid` outside FEED is ignored.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE; both banks zero; `c_out`=0; `active_buffer`=0; `in_ready`=0; `busy`=0; `done`=0; accumulators, skew registers and counters zero.
- Reset asserted mid-job aborts the job immediately; no commit follows.
- `start` sampled at edge S: `busy`=1 and `in_ready`=1 from S onward.
- Last beat accepted at edge E0: `in_ready` falls after E0.
- PE(i,j) receives beat k's operands i+j+1 edges after that beat's acceptance edge.
- PE(N−1,N−1) does its final MAC at E0+2N−1.
- Commit edge is E0+2N: `c_out` and `active_buffer` update at that edge, and `done`=1 for the following cycle only.
- `busy` falls at edge E0+2N+1.
- `k_len`=0: commit occurs 2N cycles after S and writes all-zero results.
- `start` may be asserted in the cycle `done` is high. It is sampled one edge later, in IDLE, giving back-to-back jobs with a single idle cycle.

## Test plan
- Basic 2×2 product:
  - Stimulus: N=2, unsigned, `k_len`=2; beats (`a_col`,`b_row`) = ({1,3},{5,6}) then ({2,4},{7,8}).
  - Response: `c_out` = 19,22,43,50; `done` exactly 4 cycles after the last beat; `active_buffer` 0→1.
- Signed product with bubbles:
  - Stimulus: N=4, `signed_mode`=1, `k_len`=4; A contains −128, −1, 127; random `in_valid` gaps.
  - Response: results match the signed reference model; gaps change only the `done` time, never the values.
- Back-to-back jobs:
  - Stimulus: job1 gives C1, job2 gives C2.
  - Response: `c_out`=C1 stays stable through all of job2; it switches to C2 at job2's commit edge; `active_buffer` returns to 0.
- Boundary and clamp cases:
  - Stimulus: `k_len`=0, then `k_len`=MAX_K+3 with all operands 255 unsigned.
  - Response: the first job yields all zeros 2N cycles after `start`. The second yields MAX_K·65025 per element with no wrap at default ACC_W, and `in_ready` drops after MAX_K beats.
- Reset mid-FEED:
  - Stimulus: assert `rst` low after 2 beats, release, run a fresh job.
  - Response: outputs return to zero immediately and no `done` pulse appears. The fresh job's result is correct and lands in bank 1.
- Ignored inputs:
  - Stimulus: pulse `start` during DRAIN; drive `in_valid` during IDLE.
  - Response: no effect on state, results or timing.

Source files
------------

// File: rtl/systolic_array_nxn.sv
// Output-stationary N x N systolic matrix-multiply engine: C = A * B for an
// N x K by K x N product with run-time K (clamped to MAX_K).
// Ports:
//   clk, rst (async, active-low)
//   start, k_len, signed_mode  : job request, sampled in IDLE
//   in_valid / in_ready        : operand beat handshake (ready only in FEED)
//   a_col, b_row               : one column of A and one row of B per beat
//   c_out                      : result matrix from the read bank
//   active_buffer              : bank index currently driven on c_out
//   busy, done                 : job in flight / one-cycle commit pulse
module systolic_array_nxn #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_K  = 16,
  parameter int unsigned KW     = $clog2(MAX_K + 1),
  parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(MAX_K)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 signed_mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DATA_W-1:0]  a_col,
  input  logic [N*DATA_W-1:0]  b_row,
  output logic [N*N*ACC_W-1:0] c_out,
  output logic                 active_buffer,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned PW = 2 * DATA_W + 2;
  localparam int unsigned CW = $clog2(2 * N);
  localparam int unsigned RW = N * N * ACC_W;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_COMMIT} state_t;

  state_t            state;
  logic [KW-1:0]     k_q;
  logic [KW-1:0]     beat_cnt;
  logic [CW-1:0]     drain_cnt;
  logic              sm_q;
  logic [RW-1:0]     bank0;
  logic [RW-1:0]     bank1;
  logic [RW-1:0]     acc_flat;
  logic              accept;
  logic              clr;
  logic [KW-1:0]     k_clamp;

  assign accept  = (state == S_FEED) && in_valid;
  assign clr     = (state == S_IDLE) && start;
  assign k_clamp = (k_len > KW'(MAX_K)) ? KW'(MAX_K) : k_len;

  // Extend both operands by one bit (sign or zero) so one signed multiplier
  // serves both modes; the product is then sign-extended into the accumulator.
  function automatic logic [ACC_W-1:0] mac_term(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic              sm);
    logic signed [DATA_W:0] ax;
    logic signed [DATA_W:0] bx;
    logic signed [PW-1:0]   p;
    ax = {sm & a[DATA_W-1], a};
    bx = {sm & b[DATA_W-1], b};
    p  = PW'(ax) * PW'(bx);
    return ACC_W'(p);
  endfunction

  // Input skew: an accepted beat enters a capture register (zeros otherwise),
  // then row/column g is delayed by g further registers.
  logic [DATA_W-1:0] a_edge [N];
  logic [DATA_W-1:0] b_edge [N];

  for (genvar g = 0; g < N; g++) begin : g_skew
    logic [DATA_W-1:0] a_sk [g+1];
    logic [DATA_W-1:0] b_sk [g+1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int d = 0; d <= g; d++) begin
          a_sk[d] <= '0;
          b_sk[d] <= '0;
        end
      end else if (clr) begin
        for (int d = 0; d <= g; d++) begin
          a_sk[d] <= '0;
          b_sk[d] <= '0;
        end
      end else begin
        a_sk[0] <= accept ? a_col[g*DATA_W +: DATA_W] : '0;
        b_sk[0] <= accept ? b_row[g*DATA_W +: DATA_W] : '0;
        for (int d = 1; d <= g; d++) begin
          a_sk[d] <= a_sk[d-1];
          b_sk[d] <= b_sk[d-1];
        end
      end
    end

    assign a_edge[g] = a_sk[g];
    assign b_edge[g] = b_sk[g];
  end

  // PE grid: A flows right, B flows down, each PE accumulates in place.
  logic [DATA_W-1:0] a_in   [N][N];
  logic [DATA_W-1:0] b_in   [N][N];
  logic [DATA_W-1:0] a_pass [N][N-1];
  logic [DATA_W-1:0] b_pass [N-1][N];
  logic [ACC_W-1:0]  acc    [N][N];
  logic [ACC_W-1:0]  prod   [N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = a_edge[i];
      for (int j = 1; j < N; j++) a_in[i][j] = a_pass[i][j-1];
    end
    for (int j = 0; j < N; j++) begin
      b_in[0][j] = b_edge[j];
      for (int i = 1; i < N; i++) b_in[i][j] = b_pass[i-1][j];
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        prod[i][j] = mac_term(a_in[i][j], b_in[i][j], sm_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) acc[i][j] <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N - 1; j++) a_pass[i][j] <= '0;
      for (int i = 0; i < N - 1; i++)
        for (int j = 0; j < N; j++) b_pass[i][j] <= '0;
    end else if (clr) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) acc[i][j] <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N - 1; j++) a_pass[i][j] <= '0;
      for (int i = 0; i < N - 1; i++)
        for (int j = 0; j < N; j++) b_pass[i][j] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) acc[i][j] <= acc[i][j] + prod[i][j];
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N - 1; j++) a_pass[i][j] <= a_in[i][j];
      for (int i = 0; i < N - 1; i++)
        for (int j = 0; j < N; j++) b_pass[i][j] <= b_in[i][j];
    end
  end

  // Flatten accumulators into the result layout.
  always_comb begin
    acc_flat = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        acc_flat[(i*N+j)*ACC_W +: ACC_W] = acc[i][j];
  end

  // Control FSM. The drain counter waits until the last PE's final MAC has
  // landed, then the copy into the idle bank happens on the COMMIT entry edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      k_q           <= '0;
      sm_q          <= 1'b0;
      beat_cnt      <= '0;
      drain_cnt     <= '0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      active_buffer <= 1'b0;
      bank0         <= '0;
      bank1         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            k_q       <= k_clamp;
            sm_q      <= signed_mode;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            busy      <= 1'b1;
            if (k_clamp == '0) begin
              state <= S_DRAIN;
            end else begin
              state    <= S_FEED;
              in_ready <= 1'b1;
            end
          end
        end
        S_FEED: begin
          if (in_valid) begin
            if (beat_cnt == k_q - KW'(1)) begin
              state    <= S_DRAIN;
              in_ready <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + KW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == CW'(2 * N - 1)) begin
            state         <= S_COMMIT;
            done          <= 1'b1;
            active_buffer <= ~active_buffer;
            if (active_buffer) bank0 <= acc_flat;
            else               bank1 <= acc_flat;
          end else begin
            drain_cnt <= drain_cnt + CW'(1);
          end
        end
        S_COMMIT: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read bank selected by active_buffer.
  assign c_out = active_buffer ? bank1 : bank0;

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Self-checking bench for systolic_array_nxn (N=4, DATA_W=8, MAX_K=16).
// Expected results come from a plain matrix-product model over the operand
// arrays ma/mb, with modular wrap to ACC_W.
module tb_systolic_array_nxn;

  localparam int unsigned N      = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned MAX_K  = 16;
  localparam int unsigned KW     = $clog2(MAX_K + 1);
  localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(MAX_K);
  localparam int unsigned RW     = N * N * ACC_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic [KW-1:0]        k_len = '0;
  logic                 signed_mode = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [N*DATA_W-1:0]  a_col = '0;
  logic [N*DATA_W-1:0]  b_row = '0;
  logic [RW-1:0]        c_out;
  logic                 active_buffer;
  logic                 busy;
  logic                 done;

  systolic_array_nxn #(.N(N), .DATA_W(DATA_W), .MAX_K(MAX_K)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready),
    .a_col(a_col), .b_row(b_row), .c_out(c_out),
    .active_buffer(active_buffer), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] ma [N][MAX_K];
  logic [DATA_W-1:0] mb [MAX_K][N];
  logic [RW-1:0]     last_c = '0;
  logic              exp_bank = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic longint ext(input logic [DATA_W-1:0] v, input bit sm);
    if (sm && v[DATA_W-1]) return longint'(v) - (longint'(1) << DATA_W);
    return longint'(v);
  endfunction

  // C[i][j] = sum over k of A[i][k]*B[k][j], wrapped to ACC_W bits.
  function automatic logic [RW-1:0] ref_c(input int kk, input bit sm);
    logic [RW-1:0] r;
    longint s;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < kk; k++) s += ext(ma[i][k], sm) * ext(mb[k][j], sm);
        r[(i*N+j)*ACC_W +: ACC_W] = ACC_W'(s);
      end
    return r;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < MAX_K; k++) begin
        ma[i][k] = DATA_W'($urandom);
        mb[k][i] = DATA_W'($urandom);
      end
  endtask

  task automatic fill_const(input logic [DATA_W-1:0] v);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < MAX_K; k++) begin
        ma[i][k] = v;
        mb[k][i] = v;
      end
  endtask

  // One complete job: start, feed with random bubbles, drain, commit.
  // hold: c_out must keep the previous result until this job commits.
  // poke: pulse start (and in_valid junk) while draining.
  // chain: raise start for the next job during the done cycle.
  task automatic run_job(input string tag, input int k, input bit sm, input int gap_pct,
                         input bit hold, input bit poke, input bit chain,
                         input int nk, input bit nsm);
    int kk, beats, guard, e0, n;
    logic [RW-1:0] exp_c;
    bit unstable, rdy_bad;
    kk = (k > int'(MAX_K)) ? int'(MAX_K) : k;
    exp_c = ref_c(kk, sm);
    unstable = 0;
    rdy_bad = 0;
    start = 1'b1;
    k_len = KW'(k);
    signed_mode = sm;
    step();
    start = 1'b0;
    check_bit({tag, "_busy_start"}, busy, 1'b1);
    check_bit({tag, "_ready_start"}, in_ready, kk > 0);
    beats = 0;
    guard = 0;
    while (beats < kk && guard < 1000) begin
      if (hold && c_out !== last_c) unstable = 1;
      if (in_ready !== 1'b1) rdy_bad = 1;
      in_valid = ($urandom_range(99) >= gap_pct);
      for (int i = 0; i < N; i++) begin
        a_col[i*DATA_W +: DATA_W] = in_valid ? ma[i][beats] : DATA_W'($urandom);
        b_row[i*DATA_W +: DATA_W] = in_valid ? mb[beats][i] : DATA_W'($urandom);
      end
      step();
      if (in_valid) beats++;
      guard++;
    end
    in_valid = 1'b0;
    e0 = cyc;
    check_bit({tag, "_ready_end"}, in_ready, 1'b0);
    check_bit({tag, "_ready_feed"}, rdy_bad, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      if (hold && c_out !== last_c) unstable = 1;
      if (poke) begin
        start = (n == 2);
        if (n == 2) k_len = KW'(1);
        in_valid = (n % 3 == 0);
        a_col = (N*DATA_W)'($urandom);
        b_row = (N*DATA_W)'($urandom);
      end
      step();
      n++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    check_bit({tag, "_done"}, done, 1'b1);
    check_int({tag, "_done_latency"}, cyc - e0, int'(2 * N));
    check_bit({tag, "_busy_done"}, busy, 1'b1);
    exp_bank = ~exp_bank;
    check_bit({tag, "_bank"}, active_buffer, exp_bank);
    check_vec({tag, "_c_out"}, c_out, exp_c);
    if (hold) check_bit({tag, "_c_out_stable"}, unstable, 1'b0);
    last_c = exp_c;
    if (chain) begin
      start = 1'b1;
      k_len = KW'(nk);
      signed_mode = nsm;
    end
    step();
    check_bit({tag, "_done_one_cycle"}, done, 1'b0);
    check_bit({tag, "_busy_fall"}, busy, 1'b0);
  endtask

  initial begin
    bit no_done;

    // Reset state
    rst = 1'b0;
    step();
    step();
    check_vec("rst_c_out", c_out, '0);
    check_bit("rst_bank", active_buffer, 1'b0);
    check_bit("rst_ready", in_ready, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    rst = 1'b1;
    step();

    // in_valid while idle is ignored
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      a_col = (N*DATA_W)'($urandom);
      b_row = (N*DATA_W)'($urandom);
      step();
    end
    in_valid = 1'b0;
    check_bit("idle_valid_busy", busy, 1'b0);
    check_bit("idle_valid_ready", in_ready, 1'b0);
    check_vec("idle_valid_c_out", c_out, '0);

    // Basic 2x2 product embedded in the top-left corner
    fill_const('0);
    ma[0][0] = 8'd1; ma[1][0] = 8'd3; ma[0][1] = 8'd2; ma[1][1] = 8'd4;
    mb[0][0] = 8'd5; mb[0][1] = 8'd6; mb[1][0] = 8'd7; mb[1][1] = 8'd8;
    run_job("basic", 2, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    check_int("basic_c00", int'(c_out[0*ACC_W +: ACC_W]), 19);
    check_int("basic_c01", int'(c_out[1*ACC_W +: ACC_W]), 22);
    check_int("basic_c10", int'(c_out[4*ACC_W +: ACC_W]), 43);
    check_int("basic_c11", int'(c_out[5*ACC_W +: ACC_W]), 50);

    // Signed product with extreme operands and bubbles
    fill_rand();
    ma[0][0] = 8'h80; ma[1][1] = 8'hFF; ma[2][2] = 8'h7F; ma[3][3] = 8'h80;
    ma[0][3] = 8'hFF; mb[0][0] = 8'h80; mb[3][3] = 8'h80; mb[1][2] = 8'h7F;
    run_job("signed", 4, 1'b1, 40, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Back-to-back jobs, second starts from the done cycle
    fill_rand();
    run_job("b2b_1", 7, 1'b0, 20, 1'b0, 1'b0, 1'b1, 5, 1'b1);
    fill_rand();
    run_job("b2b_2", 5, 1'b1, 20, 1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Zero-length job
    fill_rand();
    run_job("k0", 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    check_vec("k0_zero", c_out, '0);

    // Clamped length with maximal unsigned operands; start pulsed in DRAIN
    fill_const(8'hFF);
    run_job("clamp", int'(MAX_K) + 3, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    check_int("clamp_c00", int'(c_out[0 +: ACC_W]), int'(MAX_K) * 65025);

    // Reset in the middle of FEED
    fill_rand();
    start = 1'b1;
    k_len = KW'(4);
    signed_mode = 1'b0;
    step();
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        a_col[i*DATA_W +: DATA_W] = ma[i][b];
        b_row[i*DATA_W +: DATA_W] = mb[b][i];
      end
      step();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_vec("midrst_c_out", c_out, '0);
    check_bit("midrst_bank", active_buffer, 1'b0);
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_ready", in_ready, 1'b0);
    check_bit("midrst_done", done, 1'b0);
    exp_bank = 1'b0;
    last_c = '0;
    step();
    rst = 1'b1;
    no_done = 1;
    for (int c = 0; c < int'(2 * N) + 4; c++) begin
      step();
      if (done !== 1'b0) no_done = 0;
    end
    check_bit("midrst_no_done", no_done, 1'b1);
    fill_rand();
    run_job("fresh", 3, 1'b0, 30, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
